// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// cv32e40p_tmr_fault_manager_if: replica results, resync handshake and fault status bundle
interface cv32e40p_tmr_fault_manager_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
   logic             valid_i;
   logic [WIDTH-1:0] res1_i;
   logic [WIDTH-1:0] res2_i;
   logic [WIDTH-1:0] res3_i;
   logic             clear_i;
   logic             resync_ack_i;
   logic             resync_req_o;
   logic [1:0]       resync_id_o;
   logic [2:0]       disagree_o;
   logic             uncorrectable_o;
   logic [CNT_W-1:0] err_cnt1_o;
   logic [CNT_W-1:0] err_cnt2_o;
   logic [CNT_W-1:0] err_cnt3_o;
   modport master (
      output valid_i, res1_i, res2_i, res3_i, clear_i, resync_ack_i,
      input  resync_req_o, resync_id_o, disagree_o, uncorrectable_o,
             err_cnt1_o, err_cnt2_o, err_cnt3_o
   );
   modport slave (
      input  valid_i, res1_i, res2_i, res3_i, clear_i, resync_ack_i,
      output resync_req_o, resync_id_o, disagree_o, uncorrectable_o,
             err_cnt1_o, err_cnt2_o, err_cnt3_o
   );
endinterface

// File: rtl/cv32e40p_tmr_fault_manager.sv
// cv32e40p_tmr_fault_manager: TMR compare supervisor with streak-driven resync requests
// Optional per-replica error counters are built when CV32E40P_TMR_ERR_CNT_EN is defined.
module cv32e40p_tmr_fault_manager #(
   parameter int WIDTH  = 32,
   parameter int THRESH = 4,
   parameter int CNT_W  = 8
) (
   input logic clk,
   input logic rst_n,
   cv32e40p_tmr_fault_manager_if.slave bus
);
   typedef enum logic [1:0] {MONITOR, REQ, FATAL} state_t;
   state_t           state;
   logic [WIDTH-1:0] r1, r2, r3;
   logic             eq12, eq13, eq23, unc;
   logic [2:0]       f;
   logic [1:0]       fid, s_id, rid;
   logic [7:0]       s_cnt, nxt_cnt;
   logic             req, unc_q;
   logic [2:0]       dis;
   assign r1 = bus.res1_i;
   assign r2 = bus.res2_i;
   assign r3 = bus.res3_i;
   // f is one-hot of the outvoted replica; zero for clean and for all-differ
   always_comb begin
      eq12    = r1 == r2;
      eq13    = r1 == r3;
      eq23    = r2 == r3;
      unc     = !eq12 && !eq13 && !eq23;
      f       = {eq12 && !eq13, eq13 && !eq12, eq23 && !eq12};
      fid     = f[0] ? 2'd1 : f[1] ? 2'd2 : f[2] ? 2'd3 : 2'd0;
      nxt_cnt = fid == 2'd0 ? 8'd0 : fid != s_id ? 8'd1 : s_cnt == 8'hff ? s_cnt : s_cnt + 8'd1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MONITOR;
         s_cnt <= '0;
         s_id  <= '0;
         req   <= 1'b0;
         rid   <= '0;
         dis   <= '0;
         unc_q <= 1'b0;
      end else if (bus.clear_i) begin
         state <= MONITOR;
         s_cnt <= '0;
         s_id  <= '0;
         req   <= 1'b0;
         rid   <= '0;
         dis   <= '0;
         unc_q <= 1'b0;
      end else begin
         if (bus.valid_i) dis <= f;
         case (state)
            MONITOR: if (bus.valid_i) begin
               if (unc) begin
                  state <= FATAL;
                  unc_q <= 1'b1;
                  s_cnt <= '0;
                  s_id  <= '0;
               end else if (nxt_cnt == 8'(THRESH)) begin
                  state <= REQ;
                  req   <= 1'b1;
                  rid   <= fid;
                  s_cnt <= '0;
                  s_id  <= '0;
               end else begin
                  s_cnt <= nxt_cnt;
                  s_id  <= fid;
               end
            end
            REQ: if (bus.valid_i && unc) begin
               state <= FATAL;
               unc_q <= 1'b1;
               req   <= 1'b0;
               rid   <= '0;
            end else if (bus.resync_ack_i) begin
               state <= MONITOR;
               req   <= 1'b0;
               rid   <= '0;
            end
            default: ;
         endcase
      end
   end
   assign bus.resync_req_o    = req;
   assign bus.resync_id_o     = rid;
   assign bus.disagree_o      = dis;
   assign bus.uncorrectable_o = unc_q;
`ifdef CV32E40P_TMR_ERR_CNT_EN
   logic [CNT_W-1:0] c1, c2, c3;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c1 <= '0;
         c2 <= '0;
         c3 <= '0;
      end else if (bus.clear_i) begin
         c1 <= '0;
         c2 <= '0;
         c3 <= '0;
      end else if (bus.valid_i) begin
         c1 <= c1 + CNT_W'(f[0] && c1 != '1);
         c2 <= c2 + CNT_W'(f[1] && c2 != '1);
         c3 <= c3 + CNT_W'(f[2] && c3 != '1);
      end
   end
   assign bus.err_cnt1_o = c1;
   assign bus.err_cnt2_o = c2;
   assign bus.err_cnt3_o = c3;
`else
   assign bus.err_cnt1_o = {CNT_W{1'b0}};
   assign bus.err_cnt2_o = {CNT_W{1'b0}};
   assign bus.err_cnt3_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// tb_cv32e40p_tmr_fault_manager: bench for the TMR fault manager (8-bit and 2-bit counter builds)
module tb_cv32e40p_tmr_fault_manager;
   localparam int THRESH = 4;
`ifdef CV32E40P_TMR_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   cv32e40p_tmr_fault_manager_if #(.WIDTH(32), .CNT_W(8)) a ();
   cv32e40p_tmr_fault_manager_if #(.WIDTH(32), .CNT_W(2)) b ();
   cv32e40p_tmr_fault_manager #(.WIDTH(32), .THRESH(THRESH), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
   cv32e40p_tmr_fault_manager #(.WIDTH(32), .THRESH(THRESH), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
   typedef struct packed {
      logic       req;
      logic [1:0] id;
      logic [2:0] dis;
      logic       unc;
      logic [7:0] c1, c2, c3;
      logic [1:0] s1, s2, s3;
   } exp_t;
   exp_t sb[$];
   int n_chk = 0, n_fail = 0, n_step = 0;
   int m_st, m_cnt, m_id, m_rid;
   logic [2:0] m_dis;
   logic m_unc;
   int m_e[3], m_s[3];
   localparam logic [31:0] GOOD = 32'h1234_5678;
   localparam logic [31:0] BAD  = 32'hedcb_a987;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset;
      m_st = 0; m_cnt = 0; m_id = 0; m_rid = 0; m_dis = '0; m_unc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_e[i] = 0;
         m_s[i] = 0;
      end
   endtask
   // m_st: 0 monitoring, 1 request pending, 2 fatal
   task automatic model_step(input logic v, input logic [31:0] x, y, z, input logic clr, ack);
      int bad;
      if (clr) begin
         model_reset();
         return;
      end
      bad = !v ? 0 : (x == y && y == z) ? 0 : x == y ? 3 : x == z ? 2 : y == z ? 1 : 4;
      if (v) m_dis = (bad >= 1 && bad <= 3) ? 3'(1 << (bad - 1)) : 3'b000;
      if (bad >= 1 && bad <= 3) begin
         if (m_e[bad-1] < 255) m_e[bad-1]++;
         if (m_s[bad-1] < 3) m_s[bad-1]++;
      end
      if (m_st == 0 && v) begin
         if (bad == 4) begin
            m_st = 2; m_unc = 1'b1; m_cnt = 0; m_id = 0;
         end else begin
            if (bad == 0) begin
               m_cnt = 0; m_id = 0;
            end else if (bad == m_id) m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
            else begin
               m_id = bad; m_cnt = 1;
            end
            if (m_cnt == THRESH) begin
               m_st = 1; m_rid = m_id; m_cnt = 0; m_id = 0;
            end
         end
      end else if (m_st == 1) begin
         if (bad == 4) begin
            m_st = 2; m_unc = 1'b1; m_rid = 0;
         end else if (ack) begin
            m_st = 0; m_rid = 0;
         end
      end
   endtask
   function automatic exp_t model_out();
      exp_t e;
      e.req = m_st == 1;
      e.id  = 2'(m_rid);
      e.dis = m_dis;
      e.unc = m_unc;
      e.c1  = CNT_EN ? 8'(m_e[0]) : 8'd0;
      e.c2  = CNT_EN ? 8'(m_e[1]) : 8'd0;
      e.c3  = CNT_EN ? 8'(m_e[2]) : 8'd0;
      e.s1  = CNT_EN ? 2'(m_s[0]) : 2'd0;
      e.s2  = CNT_EN ? 2'(m_s[1]) : 2'd0;
      e.s3  = CNT_EN ? 2'(m_s[2]) : 2'd0;
      return e;
   endfunction
   task automatic drive(input logic v, input logic [31:0] x, y, z, input logic clr, ack);
      a.valid_i = v; a.res1_i = x; a.res2_i = y; a.res3_i = z; a.clear_i = clr; a.resync_ack_i = ack;
      b.valid_i = v; b.res1_i = x; b.res2_i = y; b.res3_i = z; b.clear_i = clr; b.resync_ack_i = ack;
   endtask
   task automatic step(input logic v, input logic [31:0] x, y, z, input logic clr = 1'b0, input logic ack = 1'b0);
      exp_t e;
      @(negedge clk);
      drive(v, x, y, z, clr, ack);
      model_step(v, x, y, z, clr, ack);
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_step++;
      check($sformatf("req@%0d", n_step), a.resync_req_o, e.req);
      check($sformatf("id@%0d", n_step), a.resync_id_o, e.id);
      check($sformatf("dis@%0d", n_step), a.disagree_o, e.dis);
      check($sformatf("unc@%0d", n_step), a.uncorrectable_o, e.unc);
      check($sformatf("cnt1@%0d", n_step), a.err_cnt1_o, e.c1);
      check($sformatf("cnt2@%0d", n_step), a.err_cnt2_o, e.c2);
      check($sformatf("cnt3@%0d", n_step), a.err_cnt3_o, e.c3);
      check($sformatf("b_req@%0d", n_step), b.resync_req_o, e.req);
      check($sformatf("b_cnt1@%0d", n_step), b.err_cnt1_o, e.s1);
      check($sformatf("b_cnt2@%0d", n_step), b.err_cnt2_o, e.s2);
      check($sformatf("b_cnt3@%0d", n_step), b.err_cnt3_o, e.s3);
   endtask
   task automatic fault(input int k, input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, k == 1 ? BAD : GOOD, k == 2 ? BAD : GOOD, k == 3 ? BAD : GOOD);
   endtask
   task automatic clean(input int n);
      for (int i = 0; i < n; i++) step(1'b1, GOOD, GOOD, GOOD);
   endtask
   task automatic idle(input int n, input logic ack = 1'b0);
      for (int i = 0; i < n; i++) step(1'b0, BAD, GOOD, 32'h0, 1'b0, ack);
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_req"}, a.resync_req_o, 0);
      check({tag, "_id"}, a.resync_id_o, 0);
      check({tag, "_dis"}, a.disagree_o, 0);
      check({tag, "_unc"}, a.uncorrectable_o, 0);
      check({tag, "_cnt"}, {a.err_cnt1_o, a.err_cnt2_o, a.err_cnt3_o}, 0);
      check({tag, "_b_req"}, b.resync_req_o, 0);
      check({tag, "_b_cnt"}, {b.err_cnt1_o, b.err_cnt2_o, b.err_cnt3_o}, 0);
   endtask
   initial begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_zero("rst");
      @(negedge clk) rst_n = 1'b1;
      repeat (10) step(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
      fault(3, 4);
      idle(2);
      idle(1, 1'b1);
      idle(1);
      fault(3, 3);
      fault(2, 1);
      fault(2, 3);
      idle(1, 1'b1);
      fault(1, 3);
      clean(1);
      fault(1, 1);
      clean(1);
      fault(1, 1);
      idle(2);
      fault(1, 1);
      idle(1);
      fault(1, 2);
      idle(1, 1'b1);
      fault(2, 4);
      step(1'b1, 32'h1, 32'h2, 32'h3);
      fault(1, 4);
      idle(1, 1'b1);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      fault(3, 4);
      step(1'b0, '0, '0, '0, 1'b1, 1'b1);
      fault(3, 4);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      fault(1, 5);
      idle(1, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
